// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath constants, types and rounding helper
package fft_pkg;

  localparam int DW_DEF = 16;
  localparam int TW_DEF = 16;
  localparam int SHW    = 2;

  // Complex sample at the widest internal width of the default datapath
  typedef struct packed {
    logic signed [DW_DEF+2:0] r;
    logic signed [DW_DEF+2:0] i;
  } cplx_t;

  // Half-LSB constant used for round-half-up before a right shift by sh
  function automatic logic signed [31:0] rnd_const(input int sh);
    return (sh > 0) ? (32'sd1 <<< (sh - 1)) : 32'sd0;
  endfunction

endpackage

// File: rtl/cmul_round.sv
// rtl/cmul_round.sv - registered complex multiply by a Q1.(TW-1) twiddle with round-half-up
module cmul_round import fft_pkg::*; #(
  parameter int XW = 18,
  parameter int TW = 16,
  parameter int YW = 19
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic signed [XW-1:0] xr,
  input  logic signed [XW-1:0] xi,
  input  logic signed [TW-1:0] wr,
  input  logic signed [TW-1:0] wi,
  output logic signed [YW-1:0] yr,
  output logic signed [YW-1:0] yi
);

  // One spare bit above the product width so the two-term sum never wraps
  localparam int PW = XW + TW + 1;
  localparam logic signed [PW-1:0] RND = PW'(rnd_const(TW - 1));

  logic signed [XW+TW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]    s_r, s_i;

  assign p_rr = xr * wr;
  assign p_ii = xi * wi;
  assign p_ri = xr * wi;
  assign p_ir = xi * wr;

  assign s_r = PW'(p_rr) - PW'(p_ii) + RND;
  assign s_i = PW'(p_ri) + PW'(p_ir) + RND;

  // Drop the Q-format fraction; YW bits hold the result of any twiddle without wrap
  always_ff @(posedge clk) begin
    if (en) begin
      yr <= YW'(s_r >>> (TW - 1));
      yi <= YW'(s_i >>> (TW - 1));
    end
  end

endmodule

// File: rtl/radix4_bfly_pipe.sv
// rtl/radix4_bfly_pipe.sv - 3-stage radix-4 butterfly with twiddles, scaling and saturation
module radix4_bfly_pipe import fft_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [SHW-1:0]       in_shift,
  input  logic signed [DW-1:0] ar,
  input  logic signed [DW-1:0] ai,
  input  logic signed [DW-1:0] br,
  input  logic signed [DW-1:0] bi,
  input  logic signed [DW-1:0] cr,
  input  logic signed [DW-1:0] ci,
  input  logic signed [DW-1:0] dr,
  input  logic signed [DW-1:0] di,
  input  logic signed [TW-1:0] w1r,
  input  logic signed [TW-1:0] w1i,
  input  logic signed [TW-1:0] w2r,
  input  logic signed [TW-1:0] w2i,
  input  logic signed [TW-1:0] w3r,
  input  logic signed [TW-1:0] w3i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out0r,
  output logic signed [DW-1:0] out0i,
  output logic signed [DW-1:0] out1r,
  output logic signed [DW-1:0] out1i,
  output logic signed [DW-1:0] out2r,
  output logic signed [DW-1:0] out2i,
  output logic signed [DW-1:0] out3r,
  output logic signed [DW-1:0] out3i,
  output logic                 out_sat
);

  localparam int XW = DW + 2;
  localparam int YW = DW + 3;
  localparam logic signed [YW:0] SMAX = (YW+1)'((1 <<< (DW - 1)) - 1);
  localparam logic signed [YW:0] SMIN = (YW+1)'(-(1 <<< (DW - 1)));

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  // Round-half-up, arithmetic shift and clamp; MSB of the result flags a clip
  function automatic logic [DW:0] scale_sat(input logic signed [YW-1:0] y,
                                            input logic [SHW-1:0] sh);
    logic signed [YW:0] t;
    t = (YW+1)'(y) + (YW+1)'(rnd_const(int'(sh)));
    t = t >>> sh;
    if (t > SMAX) return {1'b1, DW'(SMAX)};
    if (t < SMIN) return {1'b1, DW'(SMIN)};
    return {1'b0, DW'(t)};
  endfunction

  logic signed [XW-1:0] s1_x [8];
  logic signed [XW-1:0] pr, pi, mr, mi;
  logic signed [XW-1:0] x1 [8];
  logic signed [TW-1:0] wq [6];
  logic [SHW-1:0]       sh1, sh2;
  logic                 v1, v2;
  logic signed [YW-1:0] y0r, y0i;
  logic signed [YW-1:0] cy_r [1:3];
  logic signed [YW-1:0] cy_i [1:3];
  logic [DW:0]          zv [8];
  logic                 sat_any;

  // Stage 1 adder tree; inverse mode just swaps which rotation lands on X1 and X3
  always_comb begin
    pr = XW'(ar) + XW'(bi) - XW'(cr) - XW'(di);
    pi = XW'(ai) - XW'(br) - XW'(ci) + XW'(dr);
    mr = XW'(ar) - XW'(bi) - XW'(cr) + XW'(di);
    mi = XW'(ai) + XW'(br) - XW'(ci) - XW'(dr);
    s1_x[0] = XW'(ar) + XW'(br) + XW'(cr) + XW'(dr);
    s1_x[1] = XW'(ai) + XW'(bi) + XW'(ci) + XW'(di);
    s1_x[4] = XW'(ar) - XW'(br) + XW'(cr) - XW'(dr);
    s1_x[5] = XW'(ai) - XW'(bi) + XW'(ci) - XW'(di);
    s1_x[2] = in_inv ? mr : pr;
    s1_x[3] = in_inv ? mi : pi;
    s1_x[6] = in_inv ? pr : mr;
    s1_x[7] = in_inv ? pi : mi;
  end

  // Stage 1 register: sums, twiddles and shift code travel with their beat
  always_ff @(posedge clk) begin
    if (rst)     v1 <= 1'b0;
    else if (en) v1 <= in_valid;
    if (en) begin
      x1    <= s1_x;
      wq[0] <= w1r;
      wq[1] <= w1i;
      wq[2] <= w2r;
      wq[3] <= w2i;
      wq[4] <= w3r;
      wq[5] <= w3i;
      sh1   <= in_shift;
    end
  end

  for (genvar k = 1; k < 4; k++) begin : g_cmul
    cmul_round #(.XW(XW), .TW(TW), .YW(YW)) u_cmul (
      .clk (clk),
      .en  (en),
      .xr  (x1[2*k]),
      .xi  (x1[2*k+1]),
      .wr  (wq[2*k-2]),
      .wi  (wq[2*k-1]),
      .yr  (cy_r[k]),
      .yi  (cy_i[k])
    );
  end

  // Stage 2 register: X0 is delayed to line up with the twiddle products
  always_ff @(posedge clk) begin
    if (rst)     v2 <= 1'b0;
    else if (en) v2 <= v1;
    if (en) begin
      y0r <= YW'(x1[0]);
      y0i <= YW'(x1[1]);
      sh2 <= sh1;
    end
  end

  // Stage 3 scaling of all eight components and the per-beat clip flag
  always_comb begin
    zv[0] = scale_sat(y0r, sh2);
    zv[1] = scale_sat(y0i, sh2);
    for (int k = 1; k < 4; k++) begin
      zv[2*k]   = scale_sat(cy_r[k], sh2);
      zv[2*k+1] = scale_sat(cy_i[k], sh2);
    end
    sat_any = 1'b0;
    for (int k = 0; k < 8; k++) sat_any = sat_any | zv[k][DW];
  end

  // Output register; holds its beat while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      out0r <= '0; out0i <= '0; out1r <= '0; out1i <= '0;
      out2r <= '0; out2i <= '0; out3r <= '0; out3i <= '0;
    end else if (en) begin
      out_valid <= v2;
      out_sat   <= v2 && sat_any;
      out0r <= zv[0][DW-1:0];
      out0i <= zv[1][DW-1:0];
      out1r <= zv[2][DW-1:0];
      out1i <= zv[3][DW-1:0];
      out2r <= zv[4][DW-1:0];
      out2i <= zv[5][DW-1:0];
      out3r <= zv[6][DW-1:0];
      out3i <= zv[7][DW-1:0];
    end
  end

endmodule

// File: tb/tb_radix4_bfly_pipe.sv
// tb/tb_radix4_bfly_pipe.sv - self-checking bench for radix4_bfly_pipe
module tb_radix4_bfly_pipe;

  localparam int DW = 16;
  localparam int TW = 16;

  typedef struct {
    bit inv;
    int sh;
    int d[8];
    int w[6];
  } beat_t;

  typedef struct {
    int o[8];
    bit sat;
    int cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_sat;
  logic signed [DW-1:0] out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i;
  logic signed [DW-1:0] outv [8];
  beat_t cur;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  res_t exp_q[$];
  res_t rx_q[$];
  int   acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign outv[0] = out0r; assign outv[1] = out0i;
  assign outv[2] = out1r; assign outv[3] = out1i;
  assign outv[4] = out2r; assign outv[5] = out2i;
  assign outv[6] = out3r; assign outv[7] = out3i;

  radix4_bfly_pipe #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(cur.inv), .in_shift(2'(cur.sh)),
    .ar(DW'(cur.d[0])), .ai(DW'(cur.d[1])), .br(DW'(cur.d[2])), .bi(DW'(cur.d[3])),
    .cr(DW'(cur.d[4])), .ci(DW'(cur.d[5])), .dr(DW'(cur.d[6])), .di(DW'(cur.d[7])),
    .w1r(TW'(cur.w[0])), .w1i(TW'(cur.w[1])), .w2r(TW'(cur.w[2])),
    .w2i(TW'(cur.w[3])), .w3r(TW'(cur.w[4])), .w3i(TW'(cur.w[5])),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0r(out0r), .out0i(out0i), .out1r(out1r), .out1i(out1i),
    .out2r(out2r), .out2i(out2i), .out3r(out3r), .out3i(out3i),
    .out_sat(out_sat)
  );

  // Reference: DFT-4 arithmetic, exact complex product, floor-based rounding, clamp
  function automatic res_t model(beat_t b);
    res_t r;
    longint x[8];
    longint y[8];
    longint pr, pi, mr, mi, v, rc, rw, smax, smin;
    rw   = longint'(1) << (TW - 2);
    smax = (longint'(1) << (DW - 1)) - 1;
    smin = -(longint'(1) << (DW - 1));
    x[0] = longint'(b.d[0]) + b.d[2] + b.d[4] + b.d[6];
    x[1] = longint'(b.d[1]) + b.d[3] + b.d[5] + b.d[7];
    x[4] = longint'(b.d[0]) - b.d[2] + b.d[4] - b.d[6];
    x[5] = longint'(b.d[1]) - b.d[3] + b.d[5] - b.d[7];
    pr = longint'(b.d[0]) + b.d[3] - b.d[4] - b.d[7];
    pi = longint'(b.d[1]) - b.d[2] - b.d[5] + b.d[6];
    mr = longint'(b.d[0]) - b.d[3] - b.d[4] + b.d[7];
    mi = longint'(b.d[1]) + b.d[2] - b.d[5] - b.d[6];
    x[2] = b.inv ? mr : pr;  x[3] = b.inv ? mi : pi;
    x[6] = b.inv ? pr : mr;  x[7] = b.inv ? pi : mi;
    y[0] = x[0];
    y[1] = x[1];
    for (int k = 1; k < 4; k++) begin
      y[2*k]   = (x[2*k] * b.w[2*k-2] - x[2*k+1] * b.w[2*k-1] + rw) >>> (TW - 1);
      y[2*k+1] = (x[2*k] * b.w[2*k-1] + x[2*k+1] * b.w[2*k-2] + rw) >>> (TW - 1);
    end
    rc = (b.sh > 0) ? (longint'(1) << (b.sh - 1)) : 0;
    r.sat = 1'b0;
    for (int k = 0; k < 8; k++) begin
      v = (y[k] + rc) >>> b.sh;
      if (v > smax) begin v = smax; r.sat = 1'b1; end
      if (v < smin) begin v = smin; r.sat = 1'b1; end
      r.o[k] = int'(v);
    end
    r.cyc = 0;
    return r;
  endfunction

  function automatic beat_t mkb(int inv, int sh, int a0, int a1, int b0, int b1,
                                int c0, int c1, int d0, int d1);
    beat_t b;
    b.inv = inv[0];
    b.sh  = sh;
    b.d[0] = a0; b.d[1] = a1; b.d[2] = b0; b.d[3] = b1;
    b.d[4] = c0; b.d[5] = c1; b.d[6] = d0; b.d[7] = d1;
    for (int k = 0; k < 6; k++) b.w[k] = (k % 2 == 0) ? -32768 : 0;
    return b;
  endfunction

  function automatic beat_t rndb(int inv, int sh);
    beat_t b;
    b.inv = inv[0];
    b.sh  = sh;
    for (int k = 0; k < 8; k++) b.d[k] = int'($urandom_range(0, 65535)) - 32768;
    for (int k = 0; k < 6; k++) b.w[k] = int'($urandom_range(0, 65535)) - 32768;
    return b;
  endfunction

  // Output monitor: records every consumed beat with the cycle it was seen
  always begin
    @(negedge clk);
    #1;
    if (out_valid && out_ready && !rst) begin
      res_t r;
      for (int k = 0; k < 8; k++) r.o[k] = int'(outv[k]);
      r.sat = out_sat;
      r.cyc = cyc;
      rx_q.push_back(r);
    end
  end

  task automatic drive(input beat_t b);
    int g;
    g = 0;
    @(negedge clk);
    cur = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL drive_timeout: in_ready stayed 0, required 1");
    end else begin
      acc_q.push_back(cyc);
      exp_q.push_back(model(b));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, output bit ok);
    int g;
    g = 0;
    while (rx_q.size() < n && g < 500) begin
      @(negedge clk);
      #2;
      g++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    cur = mkb(0, 0, 7, 7, 7, 7, 7, 7, 7, 7);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0 || out_sat !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: out_valid=%b out_sat=%b want 0 0", out_valid, out_sat);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (outv[k] !== '0) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 0", k, outv[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    n_cmp++;
    if (rx_q.size() != 0) begin n_err++; $display("FAIL reset_drop: %0d beats emitted, want 0", rx_q.size()); end
    rx_q.delete();
  endtask

  task automatic test_directed();
    beat_t bv[9];
    int    eo[9][8];
    bit    es[9];
    bit    ok;
    res_t  r;
    int    a;
    bv[0] = mkb(0, 0, 100, 0, 0, 0, 0, 0, 0, 0);
    bv[1] = mkb(0, 0, 1000, 0, 1000, 0, 1000, 0, 1000, 0);
    bv[2] = mkb(0, 0, 0, 0, 0, 100, 0, 0, 0, 0);
    bv[3] = mkb(1, 0, 0, 0, 0, 100, 0, 0, 0, 0);
    bv[4] = mkb(0, 0, 32767, 0, 32767, 0, 32767, 0, 32767, 0);
    bv[5] = mkb(0, 2, 32767, 0, 32767, 0, 32767, 0, 32767, 0);
    bv[6] = mkb(0, 3, 5, 0, 0, 0, 0, 0, 0, 0);
    bv[7] = mkb(0, 0, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    bv[8] = mkb(0, 2, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    eo = '{'{100, 0, -100, 0, -100, 0, -100, 0},
           '{4000, 0, 0, 0, 0, 0, 0, 0},
           '{0, 100, -100, 0, 0, 100, 100, 0},
           '{0, 100, 100, 0, 0, 100, -100, 0},
           '{32767, 0, 0, 0, 0, 0, 0, 0},
           '{32767, 0, 0, 0, 0, 0, 0, 0},
           '{1, 0, -1, 0, -1, 0, -1, 0},
           '{-32768, -32768, 0, 0, 0, 0, 0, 0},
           '{-32768, -32768, 0, 0, 0, 0, 0, 0}};
    es = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
    for (int v = 0; v < 9; v++) begin
      drive(bv[v]);
      idle();
      wait_rx(1, ok);
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL dir%0d_timeout: no output, want 1 beat", v);
      end else begin
        r = rx_q.pop_front();
        a = acc_q.pop_front();
        void'(exp_q.pop_front());
        if (r.cyc - a != 3) begin n_err++; $display("FAIL dir%0d_latency: got %0d want 3", v, r.cyc - a); end
        for (int k = 0; k < 8; k++) begin
          n_cmp++;
          if (r.o[k] !== eo[v][k]) begin
            n_err++; $display("FAIL dir%0d_out[%0d]: got %0d want %0d", v, k, r.o[k], eo[v][k]);
          end
        end
        n_cmp++;
        if (r.sat !== es[v]) begin n_err++; $display("FAIL dir%0d_sat: got %b want %b", v, r.sat, es[v]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [DW-1:0] snap [8];
    bit   ok;
    res_t r, e;
    beat_t b;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          b = rndb(0, 0);
          for (int k = 0; k < 8; k++) b.d[k] = i * 8 + k + 1;
          drive(b);
        end
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", out_valid); end
        for (int k = 0; k < 8; k++) snap[k] = outv[k];
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          #1;
          n_cmp++;
          if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
          n_cmp++;
          if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold_valid: got %b want 1", out_valid); end
          for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (outv[k] !== snap[k]) begin
              n_err++; $display("FAIL stall_hold[%0d]: got %0d want %0d", k, outv[k], snap[k]);
            end
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_rx(10, ok);
    repeat (5) @(negedge clk);
    #2;
    n_cmp++;
    if (rx_q.size() != 10) begin n_err++; $display("FAIL b2b_count: got %0d want 10", rx_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      void'(acc_q.pop_front());
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (r.o[k] !== e.o[k]) begin n_err++; $display("FAIL b2b_out[%0d]: got %0d want %0d", k, r.o[k], e.o[k]); end
      end
    end
    exp_q.delete(); rx_q.delete(); acc_q.delete();
  endtask

  task automatic test_mode_toggle();
    bit   ok;
    res_t r, e;
    int   a, first;
    for (int i = 0; i < 40; i++) drive(rndb(i % 2, i % 4));
    idle();
    wait_rx(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL toggle_count: got %0d want 40", rx_q.size()); end
    first = (rx_q.size() > 0) ? rx_q[0].cyc : 0;
    for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      a = acc_q.pop_front();
      n_cmp++;
      if (r.cyc - a != 3 || r.cyc != first + i) begin
        n_err++; $display("FAIL toggle_timing%0d: latency %0d slot %0d want 3 %0d", i, r.cyc - a, r.cyc - first, i);
      end
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (r.o[k] !== e.o[k]) begin n_err++; $display("FAIL toggle%0d_out[%0d]: got %0d want %0d", i, k, r.o[k], e.o[k]); end
      end
      n_cmp++;
      if (r.sat !== e.sat) begin n_err++; $display("FAIL toggle%0d_sat: got %b want %b", i, r.sat, e.sat); end
    end
    exp_q.delete(); rx_q.delete(); acc_q.delete();
  endtask

  task automatic test_reset_inflight();
    bit   ok;
    res_t r, e;
    int   a;
    drive(rndb(0, 1));
    drive(rndb(1, 2));
    @(negedge clk);
    rst = 1'b1;
    cur = mkb(0, 0, 11, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_beat_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_sat !== 1'b0) begin
      n_err++; $display("FAIL rst_flush: out_valid=%b out_sat=%b want 0 0", out_valid, out_sat);
    end
    exp_q.delete(); acc_q.delete();
    repeat (6) @(negedge clk);
    #2;
    n_cmp++;
    if (rx_q.size() != 0) begin n_err++; $display("FAIL rst_discard: %0d beats emitted, want 0", rx_q.size()); end
    rx_q.delete();
    drive(rndb(1, 3));
    idle();
    wait_rx(1, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL post_rst_timeout: no output, want 1 beat");
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      a = acc_q.pop_front();
      if (r.cyc - a != 3) begin n_err++; $display("FAIL post_rst_latency: got %0d want 3", r.cyc - a); end
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (r.o[k] !== e.o[k]) begin n_err++; $display("FAIL post_rst_out[%0d]: got %0d want %0d", k, r.o[k], e.o[k]); end
      end
    end
  endtask

  initial begin
    cur = mkb(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_mode_toggle();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/radix4_bfly_pipe.md
Name: radix4_bfly_pipe

Overview:
- Parametrised, pipelined radix-4 DIT/DIF butterfly for the FFT datapath, successor to the combinational 4-input butterfly.
- Adds run-time forward/inverse mode, twiddle multiplication on outputs 1-3, selectable per-beat down-scaling with rounding, and saturation with an overflow flag.
- Uses a valid/ready handshake so it can stall behind the stage buffer or memory it feeds.
- One butterfly per cycle; several instances sit between reorder buffers to build 16-, 64- or 256-point FFTs.

Parameters:
- DW, 16, signed data width of each real/imag input and output component.
- TW, 16, signed twiddle width, format Q1.(TW-1); -1.0 = 1<<(TW-1) negative is exact, +1.0 not representable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_inv  in  1  0 = forward transform, 1 = inverse (sampled with beat).
- in_shift  in  2  right-shift 0..3 applied at output (sampled with beat).
- ar, ai, br, bi, cr, ci, dr, di  in  DW each  four complex inputs A..D.
- w1r, w1i, w2r, w2i, w3r, w3i  in  TW each  twiddles for outputs 1..3 (sampled with beat).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output.
- out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i  out  DW each  results.
- out_sat  out  1  at least one of the 8 output components of this beat clipped.

Behaviour:
- Reset: out_valid=0, out_sat=0, all out* data=0, all internal stage valids=0. In-flight beats are discarded and never emitted. in_ready=0 while rst=1.
- Handshake: en = !out_valid | out_ready. in_ready = en & !rst. A beat is accepted when in_valid & in_ready. An output is consumed when out_valid & out_ready.
- Output data and out_sat are held stable while out_valid=1 & out_ready=0.
- Pipeline: 3 register stages, all advanced by en. Each stage carries its own valid, inv and shift, so mode can change every beat with no bubble.
- Latency is exactly 3 cycles from accept to out_valid when out_ready=1. Throughput is 1 beat/cycle. Bubbles are not collapsed.
- S1, add/sub, full precision DW+2 bits, no loss:
  - X0 = A+B+C+D.
  - X2 = A-B+C-D.
  - Forward: X1 = A-jB-C+jD, i.e. r = Ar+Bi-Cr-Di, i = Ai-Br-Ci+Dr. X3 = A+jB-C-jD, i.e. r = Ar-Bi-Cr+Di, i = Ai+Br-Ci-Dr.
  - Inverse: X1 and X3 formulas are exchanged (sign of j flipped).
- S2, twiddle multiply:
  - Y0 = X0 passes through with a delay register.
  - Yk = Xk*Wk for k=1..3, as a 4-multiply complex product (Xr*Wr - Xi*Wi, Xr*Wi + Xi*Wr).
  - Each sum is rounded half-up: add 1<<(TW-2), then arithmetic shift right by TW-1.
  - Result is held in DW+3 bits, which covers sqrt2 growth; no wrap permitted.
- S3, scale and saturate:
  - Per component: if shift>0, add 1<<(shift-1); then arithmetic shift right by shift.
  - Clamp to [-(2^(DW-1)), 2^(DW-1)-1].
  - out_sat = OR of clamp events across all 8 components of the beat. It is per-beat, not sticky.
- Boundaries:
  - Inputs at -2^(DW-1) on all four ports do not wrap internally.
  - Twiddle -1.0 gives exact negation.
  - Simultaneous accept and emit while stalled-then-released gives no loss or duplication.
  - rst asserted together with in_valid: the beat is dropped.

Decomposition:
- Shared package fft_pkg holds:
  - default DW/TW constants;
  - a complex struct typedef parametrised by width;
  - the rounding-constant helper function;
  - the shift-code width constant.
- Sub-module cmul_round (complex multiply plus round-half-up, one register stage), instantiated 3 times in S2.
- S1 and S3 stay inline.

Test Plan:
- DW=TW=16. A=(100,0), B=C=D=0, all W=(-32768,0), shift=0, forward -> out0=(100,0), out1..3=(-100,0), out_sat=0; out_valid exactly 3 cycles after accept.
- A=B=C=D=(1000,0), shift=0 -> out0r=4000, all other components 0. Then B=(0,100), others 0, W=(-32768,0): forward -> out1=(-100,0), out3=(100,0); inv=1 -> out1=(100,0), out3=(-100,0).
- All inputs real 32767, shift=0 -> out0r=32767, out_sat=1. Same with shift=2 -> out0r=32767 (131068>>2), out_sat=0. Shift=3, A=(5,0) only, W=(-32768,0) -> out0r=1 (round-half-up of 0.625), out1r=-1.
- 10 back-to-back beats with counting data; hold out_ready=0 for 5 cycles mid-stream -> in_ready falls while the output is stalled; out* stay stable; all 10 beats emerge once each, in order.
- Mode toggling: alternate inv and shift every beat at full rate -> each output matches a per-beat reference model with no bubbles.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and out_sat=0 on the next cycle; neither beat ever appears; a new beat after reset emerges with latency 3.
